w_writeback: RTL and testbench

//   Write-back (W) stage: the M/W pipeline register and the writer side of the

---
 rtl/cpu_defs.sv | 17 +
 rtl/w_writeback_if.sv | 35 +++
 rtl/w_load_ext.sv | 37 +++
 rtl/w_writeback.sv | 107 ++++++++++
 tb/tb_w_writeback.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: write-source codes, load-type codes and the reset PC.
package cpu_defs;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_PC8  = 2'd2;
    localparam logic [1:0] WSEL_HILO = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/w_writeback_if.sv
// M/W bus: M-stage results flowing in, GRF write port and retire counter flowing out.
// master = the pipeline side driving M results; slave = the write-back stage.
interface w_writeback_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              m_valid;
    logic [DATA_W-1:0] m_pc;
    logic [REG_AW-1:0] m_rd;
    logic [1:0]        m_wsel;
    logic [2:0]        m_ld_type;
    logic [1:0]        m_addr_lo;
    logic [DATA_W-1:0] m_alu_res;
    logic [DATA_W-1:0] m_dm_rdata;
    logic [DATA_W-1:0] m_hilo;

    logic              grf_we;
    logic [REG_AW-1:0] grf_a3;
    logic [DATA_W-1:0] grf_wd;
    logic [DATA_W-1:0] w_pc;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output m_valid, m_pc, m_rd, m_wsel, m_ld_type, m_addr_lo,
               m_alu_res, m_dm_rdata, m_hilo,
        input  grf_we, grf_a3, grf_wd, w_pc, wb_count
    );

    modport slave (
        input  m_valid, m_pc, m_rd, m_wsel, m_ld_type, m_addr_lo,
               m_alu_res, m_dm_rdata, m_hilo,
        output grf_we, grf_a3, grf_wd, w_pc, wb_count
    );
endinterface

// File: rtl/w_load_ext.sv
// Load extension: picks the addressed half/byte out of the raw memory word
// and sign- or zero-extends it; unknown load types behave as LW.
module w_load_ext
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] ext
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Select the addressed half/byte, then extend according to load type
    always_comb begin
        half_v = addr_lo[1] ? raw[31:16] : raw[15:0];
        byte_v = raw[7:0];
        case (addr_lo)
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        ext = raw;
        case (ld_type)
            LD_LH:   ext = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_LHU:  ext = {{(DATA_W-16){1'b0}}, half_v};
            LD_LB:   ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_v};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/w_writeback.sv
// Write-back stage: M/W pipeline register, write-source mux into the GRF write
// port, and a counter of retired register writes.
// Optional macro WB_TRACE_EN prints one trace line per retired write.
module w_writeback
    import cpu_defs::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          REG_AW   = 5,
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_w,
    input  logic          flush_w,
    w_writeback_if.slave  wb
);

    logic              w_valid;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_pc_q;
    logic [1:0]        w_wsel;
    logic [2:0]        w_ld_type;
    logic [1:0]        w_addr_lo;
    logic [DATA_W-1:0] w_alu_res;
    logic [DATA_W-1:0] w_dm_rdata;
    logic [DATA_W-1:0] w_hilo;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic              retire;

    w_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .raw     (w_dm_rdata),
        .addr_lo (w_addr_lo),
        .ld_type (w_ld_type),
        .ext     (load_data)
    );

    // M/W register: flush only kills the instruction, leaving PC and data as-is
    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid    <= 1'b0;
            w_rd       <= '0;
            w_pc_q     <= DATA_W'(RESET_PC);
            w_wsel     <= WSEL_ALU;
            w_ld_type  <= LD_LW;
            w_addr_lo  <= 2'd0;
            w_alu_res  <= '0;
            w_dm_rdata <= '0;
            w_hilo     <= '0;
        end else if (flush_w) begin
            w_valid <= 1'b0;
            w_rd    <= '0;
        end else if (!stall_w) begin
            w_valid    <= wb.m_valid;
            w_rd       <= wb.m_rd;
            w_pc_q     <= wb.m_pc;
            w_wsel     <= wb.m_wsel;
            w_ld_type  <= wb.m_ld_type;
            w_addr_lo  <= wb.m_addr_lo;
            w_alu_res  <= wb.m_alu_res;
            w_dm_rdata <= wb.m_dm_rdata;
            w_hilo     <= wb.m_hilo;
        end
    end

    // Write-data source select from the held W-stage state
    always_comb begin
        wd = w_alu_res;
        case (w_wsel)
            WSEL_MEM:  wd = load_data;
            WSEL_PC8:  wd = w_pc_q + DATA_W'(8);
            WSEL_HILO: wd = w_hilo;
            default:   wd = w_alu_res;
        endcase
    end

    assign we     = w_valid && (w_rd != '0);
    assign retire = we && !stall_w;

    // A write retires on the edge it leaves W; a stalled write is not yet retired
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef WB_TRACE_EN
    // Trace each retired register write
    always_ff @(posedge clk) begin
        if (retire && !reset) begin
            $display("%d@%h: $%d <= %h", $time, w_pc_q, w_rd, wd);
        end
    end
`endif

    assign wb.grf_we   = we;
    assign wb.grf_a3   = w_rd;
    assign wb.grf_wd   = wd;
    assign wb.w_pc     = w_pc_q;
    assign wb.wb_count = count_q;

endmodule

// File: tb/tb_w_writeback.sv
// Self-checking bench for w_writeback: directed cases then random traffic,
// compared against a transaction-level model of the W stage.
module tb_w_writeback;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic reset;
    logic stall_w;
    logic flush_w;

    int compared   = 0;
    int mismatched = 0;

    w_writeback_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) bus ();

    w_writeback #(
        .DATA_W   (32),
        .REG_AW   (5),
        .RESET_PC (32'h0000_3000),
        .CNT_W    (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall_w (stall_w),
        .flush_w (flush_w),
        .wb      (bus)
    );

    always #5 clk = ~clk;

    // Model state: what instruction sits in W and what it will write
    logic        mdl_valid;
    logic [4:0]  mdl_rd;
    logic [31:0] mdl_pc;
    logic [31:0] mdl_wd;
    logic [31:0] mdl_cnt;

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [2:0] ld,
                                             input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * int'(lo))) & 32'hFF;
        h = (rdata >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (ld)
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] ws, input logic [2:0] ld,
                                           input logic [1:0] lo, input logic [31:0] alu,
                                           input logic [31:0] rdata, input logic [31:0] pc,
                                           input logic [31:0] hilo);
        case (ws)
            2'd0:    return alu;
            2'd1:    return ref_load(rdata, ld, lo);
            2'd2:    return pc + 32'd8;
            default: return hilo;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic exp_we;
        exp_we = mdl_valid && (mdl_rd != 5'd0);
        check_output("grf_we",   32'(bus.grf_we), 32'(exp_we));
        check_output("grf_a3",   32'(bus.grf_a3), 32'(mdl_rd));
        check_output("grf_wd",   bus.grf_wd, mdl_wd);
        check_output("w_pc",     bus.w_pc, mdl_pc);
        check_output("wb_count", bus.wb_count, mdl_cnt);
    endtask

    // One clock: advance the model with the inputs presented at this edge, then compare
    task automatic apply_stimulus();
        logic exp_we;
        @(posedge clk);
        exp_we = mdl_valid && (mdl_rd != 5'd0);
        if (reset) begin
            mdl_valid = 1'b0;
            mdl_rd    = 5'd0;
            mdl_pc    = 32'h0000_3000;
            mdl_wd    = 32'h0;
            mdl_cnt   = 32'h0;
        end else begin
            if (exp_we && !stall_w) mdl_cnt = mdl_cnt + 32'd1;
            if (flush_w) begin
                mdl_valid = 1'b0;
                mdl_rd    = 5'd0;
            end else if (!stall_w) begin
                mdl_valid = bus.m_valid;
                mdl_rd    = bus.m_rd;
                mdl_pc    = bus.m_pc;
                mdl_wd    = ref_wd(bus.m_wsel, bus.m_ld_type, bus.m_addr_lo, bus.m_alu_res,
                                   bus.m_dm_rdata, bus.m_pc, bus.m_hilo);
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    logic [2:0]  ld_tab [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [1:0]  lo_tab [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] exp_tab[4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};

    initial begin
        mdl_valid = 1'b0; mdl_rd = '0; mdl_pc = '0; mdl_wd = '0; mdl_cnt = '0;
        reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        bus.m_valid = 1'b0; bus.m_pc = '0; bus.m_rd = '0; bus.m_wsel = WSEL_ALU;
        bus.m_ld_type = LD_LW; bus.m_addr_lo = '0; bus.m_alu_res = '0;
        bus.m_dm_rdata = '0; bus.m_hilo = '0;

        // Reset state
        apply_stimulus();
        check_output("reset_w_pc", bus.w_pc, 32'h0000_3000);
        check_output("reset_we",   32'(bus.grf_we), 32'd0);
        reset = 1'b0;

        // ALU write to $8
        bus.m_valid = 1'b1; bus.m_rd = 5'd8; bus.m_wsel = WSEL_ALU; bus.m_alu_res = 32'h1234;
        apply_stimulus();
        check_output("alu_wd", bus.grf_wd, 32'h1234);
        check_output("alu_a3", 32'(bus.grf_a3), 32'd8);
        bus.m_valid = 1'b0;
        apply_stimulus();
        check_output("alu_count", bus.wb_count, 32'd1);

        // Load extension cases
        bus.m_valid = 1'b1; bus.m_rd = 5'd3; bus.m_wsel = WSEL_MEM; bus.m_dm_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 4; i++) begin
            bus.m_ld_type = ld_tab[i];
            bus.m_addr_lo = lo_tab[i];
            apply_stimulus();
            check_output($sformatf("load_%0d", i), bus.grf_wd, exp_tab[i]);
        end

        // $0 write suppressed; PC+8 source
        bus.m_rd = 5'd0; bus.m_wsel = WSEL_PC8; bus.m_pc = 32'h3010;
        apply_stimulus();
        check_output("r0_we", 32'(bus.grf_we), 32'd0);
        check_output("pc8_wd", bus.grf_wd, 32'h3018);

        // Stall holds a pending write for 3 cycles
        bus.m_rd = 5'd5; bus.m_wsel = WSEL_ALU; bus.m_alu_res = 32'hCAFE_0005;
        apply_stimulus();
        stall_w = 1'b1; bus.m_rd = 5'd9; bus.m_alu_res = 32'h0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("stall_we", 32'(bus.grf_we), 32'd1);
            check_output("stall_a3", 32'(bus.grf_a3), 32'd5);
        end
        stall_w = 1'b0;
        apply_stimulus();

        // Flush and stall together
        bus.m_rd = 5'd7; bus.m_pc = 32'h0000_4444;
        apply_stimulus();
        flush_w = 1'b1; stall_w = 1'b1; bus.m_pc = 32'h0000_5555;
        apply_stimulus();
        check_output("flush_we", 32'(bus.grf_we), 32'd0);
        check_output("flush_pc", bus.w_pc, 32'h0000_4444);
        flush_w = 1'b0; stall_w = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 59) == 0);
            stall_w        = ($urandom_range(0, 3) == 0);
            flush_w        = ($urandom_range(0, 7) == 0);
            bus.m_valid    = ($urandom_range(0, 4) != 0);
            bus.m_rd       = 5'($urandom_range(0, 31));
            bus.m_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.m_wsel     = 2'($urandom_range(0, 3));
            bus.m_ld_type  = 3'($urandom_range(0, 7));
            bus.m_addr_lo  = 2'($urandom_range(0, 3));
            bus.m_alu_res  = $urandom;
            bus.m_dm_rdata = $urandom;
            bus.m_hilo     = $urandom;
            apply_stimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
